// File: rtl/fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads the front bank, renderer writes the back bank.
// Read data returns 2 cycles after disp_req; writes stall while a read or a pending swap holds the port.
module fb_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 4,
    parameter int FB_DEPTH = 384000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              vblank,
    output logic              front_sel,
    output logic [7:0]        wr_drop_cnt,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(FB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_SWAP    = 2'd2
    } swap_st_e;

    swap_st_e          state_q, state_d;
    logic              front_sel_q, front_sel_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_oor_q, rd_oor_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;

    logic disp_oor;
    logic wr_oor;

    assign disp_oor = (disp_addr >= DEPTH_L);
    assign wr_oor   = (wr_addr >= DEPTH_L);

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        drop_cnt_d   = drop_cnt_q;
        addr_d       = addr_q;
        rd_vld_d     = 1'b0;
        rd_oor_d     = 1'b0;
        wr_ready     = 1'b0;
        ram_we       = 1'b0;
        ram_wdata    = {DATA_W{1'b0}};
        swap_ack     = 1'b0;

        // Reads always win the port; the bank bit rides in the RAM address,
        // so in-flight reads keep their source bank across a swap.
        if (disp_req) begin
            addr_d   = {front_sel_q, (disp_oor ? {ADDR_W{1'b0}} : disp_addr)};
            rd_vld_d = 1'b1;
            rd_oor_d = disp_oor;
        end else if (wr_valid && (state_q != S_PENDING)) begin
            wr_ready = 1'b1;
            if (!wr_oor) begin
                addr_d    = {~front_sel_q, wr_addr};
                ram_we    = 1'b1;
                ram_wdata = wr_data;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        disp_valid_d = rd_vld_q;
        disp_data_d  = disp_data_q;
        if (rd_vld_q) begin
            disp_data_d = rd_oor_q ? {DATA_W{1'b1}} : ram_rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (swap_req) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (vblank) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                swap_ack    = 1'b1;
                front_sel_d = ~front_sel_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            front_sel_q  <= 1'b0;
            drop_cnt_q   <= 8'd0;
            addr_q       <= '0;
            rd_vld_q     <= 1'b0;
            rd_oor_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            drop_cnt_q   <= drop_cnt_d;
            addr_q       <= addr_d;
            rd_vld_q     <= rd_vld_d;
            rd_oor_q     <= rd_oor_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign ram_addr    = addr_d;
    assign front_sel   = front_sel_q;
    assign wr_drop_cnt = drop_cnt_q;
    assign disp_valid  = disp_valid_q;
    assign disp_data   = disp_data_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios then random traffic, checked against a pixel-array model.
module tb_fb_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 4;
    localparam int DEPTH = 384000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          swap_ack;
    logic          vblank;
    logic          front_sel;
    logic [7:0]    wr_drop_cnt;
    logic [AW:0]   ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .vblank     (vblank),
        .front_sel  (front_sel),
        .wr_drop_cnt(wr_drop_cnt),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Single-port RAM with one cycle of read latency, both banks.
    bit [DW-1:0] ram [0:(1<<(AW+1))-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference: pixel contents per bank, displayed bank, swap progress, drop count.
    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rd_exp_t;

    bit [DW-1:0] ref_pix [0:1][0:DEPTH-1];
    rd_exp_t     exp_q[$];
    bit          m_front;
    bit          m_pending;
    bit          m_swapping;
    int          m_drops;
    int          cyc;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_tot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_front    = 1'b0;
        m_pending  = 1'b0;
        m_swapping = 1'b0;
        m_drops    = 0;
    endtask

    // Check one cycle at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        bit rd, wok, win, ev;
        int bank;
        @(negedge clk);
        rd  = disp_req;
        wok = !disp_req && wr_valid && !m_pending;
        win = (wr_addr < DEPTH);
        chk("wr_ready", 32'(wr_ready), 32'(wok));
        chk("ram_we", 32'(ram_we), 32'(wok && win));
        chk("swap_ack", 32'(swap_ack), 32'(m_swapping));
        chk("front_sel", 32'(front_sel), 32'(m_front));
        chk("wr_drop_cnt", 32'(wr_drop_cnt), 32'(m_drops));
        if (rd) begin
            chk("rd_ram_addr", 32'(ram_addr),
                (32'(m_front) << AW) | ((disp_addr >= DEPTH) ? 32'd0 : 32'(disp_addr)));
        end else if (wok && win) begin
            chk("wr_ram_addr", 32'(ram_addr), (32'(!m_front) << AW) | 32'(wr_addr));
            chk("wr_ram_wdata", 32'(ram_wdata), 32'(wr_data));
        end
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("disp_valid", 32'(disp_valid), 32'(ev));
        if (ev) begin
            chk("disp_data", 32'(disp_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end
        bank = m_front ? 1 : 0;
        if (rd) exp_q.push_back('{cyc + 2, (disp_addr >= DEPTH) ? 4'hF : ref_pix[bank][disp_addr]});
        if (wok && win) ref_pix[1 - bank][wr_addr] = wr_data;
        if (wok && !win && m_drops < 255) m_drops++;
        if (m_swapping) begin
            m_front    = !m_front;
            m_swapping = 1'b0;
        end else if (m_pending) begin
            if (vblank) begin
                m_pending  = 1'b0;
                m_swapping = 1'b1;
            end
        end else if (swap_req) begin
            m_pending = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit dr, input int da, input bit wv, input int wa, input int wd,
                        input bit sr, input bit vb);
        disp_req  = dr;
        disp_addr = da[AW-1:0];
        wr_valid  = wv;
        wr_addr   = wa[AW-1:0];
        wr_data   = wd[DW-1:0];
        swap_req  = sr;
        vblank    = vb;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        chk({tag, "_front_sel"}, 32'(front_sel), 32'd0);
        chk({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(wr_drop_cnt), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        swap_req = 0; vblank = 0;
        cyc = 0;
        model_reset();
        #12;
        check_reset_outputs("por");
        chk("por_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Write to back bank, swap at vblank, read it back from the new front.
        step(0, 0, 1, 5, 3, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 5, 0, 0, 0, 0, 0);
        idle(3);

        // Reads hold the port for 10 cycles while a write waits.
        for (int i = 0; i < 10; i++) step(1, i, 1, 7, 9, 0, 0);
        step(0, 0, 1, 7, 9, 0, 0);
        idle(3);

        // Long pending swap with a repeated request, writes stalled throughout.
        step(0, 0, 1, 11, 2, 1, 0);
        for (int i = 0; i < 19; i++) step(i % 4 == 0, i, 1, 11, 2, i == 5, 0);
        step(0, 0, 1, 11, 2, 0, 1);
        step(0, 0, 1, 12, 4, 1, 0);
        idle(3);

        // Out-of-range writes and reads, drop counter saturation.
        for (int i = 0; i < 3; i++) step(0, 0, 1, DEPTH, 1, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 1, DEPTH + i, 1, 0, 0);
        step(1, 400000, 0, 0, 0, 0, 0);
        idle(3);

        // Reads straddling the bank toggle: distinct data in the two banks at pixel 9.
        step(0, 0, 1, 9, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 1, 9, 10, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 9, 0, 0, 0, 0, 1);
        step(1, 9, 0, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0, 0);
        idle(3);

        // Reset mid-burst with reads in flight and a swap pending.
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 9, 0, 0, 0, 0, 0);
        step(1, 10, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        disp_req = 0; wr_valid = 0; swap_req = 0; vblank = 0;
        #2;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk); @(posedge clk); #3;
        rstn = 1'b1;
        idle(3);
        step(0, 0, 1, 20, 6, 0, 0);
        idle(2);

        // Random traffic, vblank in periodic windows.
        for (int i = 0; i < 3000; i++) begin
            int da, wa;
            da = ($urandom % 8 == 0) ? DEPTH - 1 + int'($urandom % 3) : int'($urandom % 16);
            wa = ($urandom % 8 == 0) ? DEPTH - 1 + int'($urandom % 3) : int'($urandom % 16);
            step($urandom % 3 == 0, da, $urandom % 2 == 0, wa, int'($urandom % 16),
                 $urandom % 20 == 0, (i % 100) >= 85);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port, 4-bit-per-pixel framebuffer RAM between the LCD scan-out path (reads) and the renderer/sprite engine (writes).
- Implements double buffering: display reads the front bank while the renderer writes the back bank.
- Swaps banks only during vertical blanking, on request.
- Sits between lcd_color's RAM address/data ports and the framebuffer RAM.

Parameters:
ADDR_W, 19, pixel address width within one bank
DATA_W, 4, colour-index width
FB_DEPTH, 384000, valid pixels per bank (800x480); addresses >= FB_DEPTH are out of range

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
disp_req  in  1  display read request, one pixel per cycle
disp_addr  in  ADDR_W  display pixel address
disp_data  out  DATA_W  colour index returned to display
disp_valid  out  1  disp_data valid
wr_valid  in  1  renderer write request
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_W  renderer pixel address (back bank)
wr_data  in  DATA_W  renderer colour index
swap_req  in  1  single-cycle request to swap banks
swap_ack  out  1  single-cycle pulse when swap takes effect
vblank  in  1  high during vertical blanking (synchronous to clk)
front_sel  out  1  bank currently displayed
wr_drop_cnt  out  8  saturating count of out-of-range writes
ram_addr  out  ADDR_W+1  RAM address, MSB = bank
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read latency

Behaviour:
- Reset (rstn low, async):
  - All outputs 0, front_sel=0, wr_drop_cnt=0, swap FSM in IDLE.
  - Read pipeline flushed; disp_valid stays 0 until a post-reset read completes.
- Arbitration, per cycle, fixed priority:
  1. disp_req=1:
     - RAM read of {front_sel, disp_addr}; ram_we=0; wr_ready=0.
     - If disp_addr >= FB_DEPTH: ram_addr={front_sel,0}, and the read is tagged out-of-range.
  2. Otherwise, wr_valid=1 and FSM not PENDING:
     - wr_ready=1.
     - If wr_addr < FB_DEPTH: ram_addr={~front_sel, wr_addr}, ram_we=1, ram_wdata=wr_data.
     - Else: no RAM write; wr_drop_cnt increments, saturating at 255.
  3. Otherwise: ram_we=0, ram_addr held.
- wr_ready is combinational from disp_req, wr_valid and FSM state. A write completes in the cycle wr_valid & wr_ready.
- Read latency:
  - disp_req in cycle N gives disp_valid=1 and disp_data registered in cycle N+2: RAM latency 1, plus 1 output register.
  - Out-of-range reads return disp_data=4'hF (black) with disp_valid=1.
  - disp_valid is 0 on non-request cycles; disp_data holds its last value.
  - Back-to-back requests yield back-to-back valid data.
- Bank tag:
  - The bank used by a read is captured at issue.
  - A swap while reads are in flight does not alter their source; reads already issued return data from the old front bank.
- Swap FSM:
  - IDLE: swap_req=1 -> PENDING.
  - PENDING:
    - Writes are stalled (wr_ready=0); reads are unaffected.
    - If vblank=1 -> SWAP. This is evaluated in the cycle of entry or later.
  - SWAP, one cycle: front_sel toggles (visible next cycle), swap_ack=1, -> IDLE.
  - swap_req in PENDING or SWAP is ignored and does not queue.
  - swap_req and vblank high in the same IDLE cycle: go to PENDING only; the swap happens the next cycle if vblank is still high.
- Simultaneous disp_req and wr_valid: the read wins, the write stalls, and the renderer must hold wr_addr/wr_data stable.
- wr_drop_cnt is not cleared by swap; only reset clears it.

Test Plan:
- Reset, then write wr_addr=5/data=3 (front_sel=0), swap at vblank, then read disp_addr=5 -> ram_addr bit19=1 on write; swap_ack pulses once; disp_data=3 with disp_valid exactly 2 cycles after disp_req.
- disp_req held high 10 cycles with wr_valid=1 -> wr_ready=0 for all 10 cycles; write commits the first cycle after disp_req drops; 10 consecutive disp_valid pulses.
- swap_req with vblank=0 for 20 cycles, then vblank=1 -> wr_ready=0 throughout PENDING; front_sel toggles the cycle after SWAP; second swap_req during PENDING produces no extra swap_ack.
- Write wr_addr=384000 three times and 300 times -> no ram_we; wr_drop_cnt=3, then saturates at 255; read disp_addr=400000 -> disp_data=4'hF, disp_valid=1.
- Reads issued the cycle before and the cycle of SWAP -> both return data from the old front bank; a read issued after the toggle returns new-bank data.
- Assert rstn low mid-burst with reads in flight and FSM in PENDING -> disp_valid=0, front_sel=0, swap_ack=0, FSM IDLE; no stale disp_valid after release.
